uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 217, meaning i_clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_rx  input  1  serial line, asynchronous to i_clk, idle high, 8N1, LSB first.
REQ-005 SHALL have port i_pop  input  1  consume FIFO head byte this cycle.
REQ-006 SHALL have port i_clr_err  input  1  clear sticky error flags.
REQ-007 SHALL have port o_data  output  8  FIFO head byte, valid while o_valid=1, 8'h00 when empty.
REQ-008 SHALL have port o_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port o_count  output  3  FIFO occupancy, 0..4.
REQ-010 SHALL have port o_overrun  output  1  sticky: byte dropped, FIFO full.
REQ-011 SHALL have port o_frame_err  output  1  sticky: stop bit sampled low.

Function
REQ-012 SHALL pass i_rx through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with a 16-bit cycle counter and 3-bit bit index.
REQ-014 IDLE: on rxs=0 -> START, counter cleared; that cycle is cycle 0 of the frame.
REQ-015 START: at cycle BAUD_DIV/2 (integer division), rxs=0 -> DATA, bit index 0; rxs=1 -> IDLE (glitch rejected, no flag).
REQ-016 DATA: sample bit n at frame cycle BAUD_DIV/2+(n+1)*BAUD_DIV into shift register LSB first; after bit 7 -> STOP.
REQ-017 STOP: sample at frame cycle BAUD_DIV/2+9*BAUD_DIV; rxs=1 -> push byte, -> IDLE; rxs=0 -> byte discarded, o_frame_err set, -> WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rxs=1, then -> IDLE; no start detection meanwhile.
REQ-019 FIFO: 4 entries, 2-bit wrapping read/write pointers, o_count = occupancy; o_data combinational from head entry.
REQ-020 Push takes effect at the stop-sample edge; o_valid/o_count reflect it the following cycle.
REQ-021 Pop with o_valid=1 advances read pointer; pop with o_valid=0 SHALL be ignored, no state change.
REQ-022 Push with count=4 and no pop SHALL drop the byte and set o_overrun; FIFO contents unchanged.
REQ-023 Simultaneous push and pop at count=4 SHALL accept both: count stays 4, no overrun.
REQ-024 Simultaneous push and pop at count=0 SHALL ignore pop: count becomes 1.
REQ-025 i_clr_err SHALL clear o_overrun and o_frame_err next cycle; a set event in the same cycle wins (flag stays 1).
REQ-026 No receive activity SHALL affect FIFO contents except by REQ-017/REQ-022.

Reset
REQ-027 i_reset SHALL asynchronously force state IDLE, counters 0, pointers 0, synchronizer flops 1, o_valid=0, o_count=0, o_data=8'h00, o_overrun=0, o_frame_err=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no push and no flag; after release, next falling edge starts a new frame.
REQ-029 FIFO storage array need not be reset; o_data SHALL be gated to 8'h00 while empty.

Verification (BAUD_DIV=16)
REQ-030 Frame 0xA5, valid stop -> o_valid=1, o_data=8'hA5, o_count=1; pulse i_pop -> o_valid=0, o_count=0.
REQ-031 i_rx low 4 cycles then high -> no push, o_count=0, o_frame_err=0; following frame 0x3C received as 8'h3C.
REQ-032 Frame 0x3C with stop bit low, line held low 40 cycles then high -> o_frame_err=1, o_count=0; next frame 0x55 -> o_data=8'h55; i_clr_err -> o_frame_err=0.
REQ-033 Five frames 0x01..0x05, no pops -> o_count=4, o_overrun=1; four pops yield 01,02,03,04 then o_valid=0.
REQ-034 FIFO full, i_pop asserted in the 5th frame's stop-sample cycle -> o_count=4, o_overrun=0, head=8'h02, tail=8'h05.
REQ-035 i_reset pulsed during bit 3 of a frame -> all outputs reset values; next frame 0x81 received as 8'h81.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 serial receiver with a 4-entry receive FIFO and sticky error flags.
//   The serial input is synchronized, a start bit is qualified at mid-bit,
//   eight data bits are shifted in LSB first and the stop bit is checked
//   before the byte is pushed.
//
// Parameters
//   BAUD_DIV     i_clk cycles per serial bit (4..65535)
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_reset      asynchronous, active-high reset
//   i_rx         serial line (asynchronous, idle high)
//   i_pop        consume the FIFO head byte this cycle
//   i_clr_err    clear o_overrun and o_frame_err
//   o_data       FIFO head byte, 8'h00 while the FIFO is empty
//   o_valid      FIFO non-empty
//   o_count      FIFO occupancy, 0..4
//   o_overrun    sticky: a received byte was dropped because the FIFO was full
//   o_frame_err  sticky: a stop bit was sampled low
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned BAUD_DIV = 217
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    input  logic       i_pop,
    input  logic       i_clr_err,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic [2:0] o_count,
    output logic       o_overrun,
    output logic       o_frame_err
);

    // r_cnt counts cycles since the last reference point (start detection or
    // previous sample); it reads 0 one cycle after that point, so a sample
    // "N cycles later" happens when r_cnt == N-1. Per-bit counting keeps the
    // counter within 16 bits for any legal BAUD_DIV.
    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;

    logic        r_rx_meta;
    logic        r_rx_sync;

    logic [7:0]  r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic        r_overrun;
    logic        r_frame_err;

    logic        w_rxs;
    logic        w_stop_sample;
    logic        w_push;
    logic        w_frame_bad;
    logic        w_pop;
    logic        w_full;
    logic        w_write;
    logic        w_drop;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer; flops reset high so reset never looks like a
    // start bit.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rxs = r_rx_sync;

    // -----------------------------------------------------------------------
    // Decode of the stop-sample cycle and FIFO handshakes
    // -----------------------------------------------------------------------
    assign w_stop_sample = (r_state == S_STOP) && (r_cnt == BIT_M1);
    assign w_push        = w_stop_sample && w_rxs;
    assign w_frame_bad   = w_stop_sample && !w_rxs;
    assign w_pop         = i_pop && (r_count != 3'd0);
    assign w_full        = (r_count == 3'd4);
    // A pop in the same cycle frees the slot the push needs.
    assign w_write       = w_push && (!w_full || w_pop);
    assign w_drop        = w_push && w_full && !w_pop;

    // -----------------------------------------------------------------------
    // Receive FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 16'd0;
                    if (!w_rxs) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= 16'd0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;       // glitch, not a start bit
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == BIT_M1) begin
                        r_cnt   <= 16'd0;
                        r_shift <= {w_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == BIT_M1) begin
                        r_cnt   <= 16'd0;
                        r_state <= w_rxs ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    r_cnt <= 16'd0;
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; o_data is gated while empty, so stale
    // entries are never visible.
    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // -----------------------------------------------------------------------
    // Sticky error flags; a set event outranks a clear in the same cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_bad) begin
                r_frame_err <= 1'b1;
            end else if (i_clr_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign o_valid     = (r_count != 3'd0);
    assign o_data      = o_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign o_count     = r_count;
    assign o_overrun   = r_overrun;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx at BAUD_DIV=16. Frames are driven one bit per
//   16 clock cycles, changing on falling edges; outputs are sampled on
//   falling edges.
//
//   Timing used by the frame task: with i_rx changed at falling edge N0, the
//   synchronized line shows that value for frame cycle 0, whose closing
//   rising edge is the third one after N0. The stop sample is frame cycle
//   8 + 9*16 = 152, so an input applied at falling edge N154 is seen on the
//   stop-sample edge.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BAUD = 16;

    logic       i_clk;
    logic       i_reset;
    logic       i_rx;
    logic       i_pop;
    logic       i_clr_err;
    logic [7:0] o_data;
    logic       o_valid;
    logic [2:0] o_count;
    logic       o_overrun;
    logic       o_frame_err;

    int checks = 0;
    int errors = 0;

    uart_rx #(.BAUD_DIV(BAUD)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx        (i_rx),
        .i_pop       (i_pop),
        .i_clr_err   (i_clr_err),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_count     (o_count),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Drive one full frame (start, 8 data bits LSB first, stop). Optional
    // pop / clear pulses land on the stop-sample edge. i_rx is left at the
    // stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic pop_at_stop, input logic clr_at_stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int j = 0; j < 10 * BAUD; j++) begin
            i_rx      = fr[j / BAUD];
            i_pop     = pop_at_stop && (j == 154);
            i_clr_err = clr_at_stop && (j == 154);
            @(negedge i_clk);
        end
        i_pop     = 1'b0;
        i_clr_err = 1'b0;
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic pulse_pop;
        i_pop = 1'b1;
        @(negedge i_clk);
        i_pop = 1'b0;
    endtask

    task automatic pulse_clr;
        i_clr_err = 1'b1;
        @(negedge i_clk);
        i_clr_err = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_reset;
        i_reset   = 1'b1;
        i_rx      = 1'b1;
        i_pop     = 1'b0;
        i_clr_err = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_valid, o_count, o_data, o_overrun, o_frame_err} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b count=%0d data=%h ovr=%b ferr=%b required all 0",
                     o_valid, o_count, o_data, o_overrun, o_frame_err);
        end
        i_reset = 1'b0;
        idle(4);
    endtask

    task automatic test_single_byte;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'hA5 || o_count !== 3'd1) begin
            errors++;
            $display("FAIL single_rx got valid=%b data=%h count=%0d required 1 a5 1",
                     o_valid, o_data, o_count);
        end
        pulse_pop;
        checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0 || o_data !== 8'h00) begin
            errors++;
            $display("FAIL single_pop got valid=%b count=%0d data=%h required 0 0 00",
                     o_valid, o_count, o_data);
        end
        // Pop on an empty FIFO must change nothing.
        pulse_pop;
        checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0) begin
            errors++;
            $display("FAIL empty_pop got valid=%b count=%0d required 0 0", o_valid, o_count);
        end
    endtask

    task automatic test_glitch;
        i_rx = 1'b0;
        repeat (4) @(negedge i_clk);
        idle(40);
        checks++;
        if (o_count !== 3'd0 || o_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject got count=%0d ferr=%b required 0 0", o_count, o_frame_err);
        end
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (o_data !== 8'h3C || o_count !== 3'd1) begin
            errors++;
            $display("FAIL glitch_next got data=%h count=%0d required 3c 1", o_data, o_count);
        end
        pulse_pop;
    endtask

    task automatic test_frame_error;
        // Clear requested on the very edge that sets the flag: set must win.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        i_rx = 1'b0;
        repeat (40 - BAUD) @(negedge i_clk);
        idle(8);
        checks++;
        if (o_frame_err !== 1'b1 || o_count !== 3'd0) begin
            errors++;
            $display("FAIL frame_err got ferr=%b count=%0d required 1 0", o_frame_err, o_count);
        end
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (o_data !== 8'h55 || o_count !== 3'd1) begin
            errors++;
            $display("FAIL after_ferr got data=%h count=%0d required 55 1", o_data, o_count);
        end
        pulse_clr;
        checks++;
        if (o_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL ferr_clear got %b required 0", o_frame_err);
        end
        pulse_pop;
    endtask

    task automatic test_overrun;
        logic [7:0] exp_b [4];
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, 1'b0, 1'b0);
            idle(2);
        end
        checks++;
        if (o_count !== 3'd4 || o_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun got count=%0d ovr=%b required 4 1", o_count, o_overrun);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_b[k]) begin
                errors++;
                $display("FAIL ovr_drain%0d got valid=%b data=%h required 1 %h",
                         k, o_valid, o_data, exp_b[k]);
            end
            pulse_pop;
        end
        checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0) begin
            errors++;
            $display("FAIL ovr_empty got valid=%b count=%0d required 0 0", o_valid, o_count);
        end
        pulse_clr;
        checks++;
        if (o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got %b required 0", o_overrun);
        end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] exp_b [4];
        exp_b = '{8'h02, 8'h03, 8'h04, 8'h05};
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'(k), 1'b1, 1'b0, 1'b0);
            idle(2);
        end
        send_frame(8'h05, 1'b1, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (o_count !== 3'd4 || o_overrun !== 1'b0 || o_data !== 8'h02) begin
            errors++;
            $display("FAIL full_pushpop got count=%0d ovr=%b head=%h required 4 0 02",
                     o_count, o_overrun, o_data);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_data !== exp_b[k]) begin
                errors++;
                $display("FAIL full_drain%0d got %h required %h", k, o_data, exp_b[k]);
            end
            pulse_pop;
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] fr;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(2);
        // Start a frame and abandon it half way through data bit 3.
        fr = {1'b1, 8'h81, 1'b0};
        for (int j = 0; j < 4 * BAUD + BAUD / 2; j++) begin
            i_rx = fr[j / BAUD];
            @(negedge i_clk);
        end
        #2 i_reset = 1'b1;
        #1;
        checks++;
        if ({o_valid, o_count, o_data, o_overrun, o_frame_err} !== 14'h0) begin
            errors++;
            $display("FAIL midframe_reset got valid=%b count=%0d data=%h ovr=%b ferr=%b required all 0",
                     o_valid, o_count, o_data, o_overrun, o_frame_err);
        end
        i_rx = 1'b1;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        idle(200);
        checks++;
        if (o_count !== 3'd0 || o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL midframe_abandon got count=%0d ferr=%b ovr=%b required 0 0 0",
                     o_count, o_frame_err, o_overrun);
        end
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (o_data !== 8'h81 || o_count !== 3'd1) begin
            errors++;
            $display("FAIL midframe_next got data=%h count=%0d required 81 1", o_data, o_count);
        end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_glitch;
        test_frame_error;
        test_overrun;
        do_reset;
        test_full_push_pop;
        test_reset_mid_frame;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
